// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fq_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fq_entry_t;

    // Instruction fetch is word granular; low address bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fq_ram.sv
// Prefetch queue storage: DEPTH x {pc, inst}, one write port, one async read port.
module fq_ram
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  fq_entry_t     i_wdata,
    input  logic [AW-1:0] i_raddr,
    output fq_entry_t     o_rdata
);

    fq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue feeding decode; credit-based issue, flush on redirect.
// Optional FETCH_QUEUE_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fq_state_e       r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic            r_inflight;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic          w_issue;
    logic          w_head_vld;
    logic          w_bypass;
    logic          w_enq;
    logic          w_deq;
    logic [CW-1:0] w_credits;
    fq_entry_t     w_wdata;
    fq_entry_t     w_head;

    // An outstanding request already owns a slot, so a response always fits.
    assign w_credits = r_count + CW'(r_inflight);
    assign w_issue   = (r_state == FETCH) && !redirect && (w_credits < CW'(DEPTH));

    assign w_head_vld = (r_count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = r_inflight && !redirect && !stall && !w_head_vld;
`else
    assign w_bypass = 1'b0;
`endif

    // Redirect kills the response arriving this cycle and blocks dequeue.
    assign w_enq = r_inflight && !redirect && !w_bypass;
    assign w_deq = w_head_vld && !stall && !redirect;

    assign w_wdata = '{pc: r_resp_pc, inst: imem_rdata};

    fq_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_enq),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_head)
    );

    assign imem_req  = w_issue;
    assign imem_addr = r_fetch_pc;

    always_comb begin
        inst_valid = 1'b0;
        inst       = NOP_INST;
        inst_pc    = '0;
        if (w_head_vld) begin
            inst_valid = 1'b1;
            inst       = w_head.inst;
            inst_pc    = w_head.pc;
        end else if (w_bypass) begin
            inst_valid = 1'b1;
            inst       = imem_rdata;
            inst_pc    = r_resp_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= BOOT;
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= '0;
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_state    <= FLUSH;
            r_fetch_pc <= word_align(redirect_pc);
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            unique case (r_state)
                BOOT:    r_state <= FETCH;
                FETCH:   r_state <= FETCH;
                FLUSH:   r_state <= FETCH;
                default: r_state <= BOOT;
            endcase

            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
                r_resp_pc  <= r_fetch_pc;
            end

            if (w_enq) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + AW'(1);
            end

            unique case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
